// File: rtl/seg7_scan_ctrl_if.sv
// Display-controller bus: score logic drives digit data, the scan controller
// returns the board pin levels and a frame-boundary pulse.
interface seg7_scan_ctrl_if #(
    parameter int NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank_in;
    logic                    lzs_en;
    logic [7:0]              segment;
    logic [NUM_DIGITS-1:0]   enable;
    logic                    frame_tick;

    modport master (
        output digits_in, dp_in, blank_in, lzs_en,
        input  segment, enable, frame_tick
    );

    modport slave (
        input  digits_in, dp_in, blank_in, lzs_en,
        output segment, enable, frame_tick
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment scanner with prescaler, blank time,
// per-frame input snapshot, leading-zero suppression and optional hex glyphs.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS   = 8,
    parameter int DIV          = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int HEX_MODE     = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    seg7_scan_ctrl_if.slave   bus
);
    localparam int PCNT_W = $clog2(DIV);
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [PCNT_W-1:0]           pcnt;
    logic [IDX_W-1:0]            idx;
    logic [NUM_DIGITS-1:0][3:0]  snap_digits;
    logic [NUM_DIGITS-1:0]       snap_dp;
    logic [NUM_DIGITS-1:0]       snap_blank;
    logic                        snap_lzs;
    logic [7:0]                  seg_q;
    logic [NUM_DIGITS-1:0]       en_q;
    logic                        tick_q;

    logic                        slot_end;
    logic                        frame_end;
    logic                        in_blank;
    logic [NUM_DIGITS-1:0][7:0]  glyph;
    logic [7:0]                  seg_next;
    logic [NUM_DIGITS-1:0]       en_next;

    assign slot_end  = (pcnt == PCNT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    generate
        if (BLANK_CYCLES > 0) begin : g_blank
            assign in_blank = (pcnt < PCNT_W'(BLANK_CYCLES));
        end else begin : g_no_blank
            assign in_blank = 1'b0;
        end
    endgenerate

    // abcdefg, 0 = lit; codes above 9 go dark unless hex glyphs are enabled.
    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] g;
        case (code)
            4'h0:    g = 7'b0000001;
            4'h1:    g = 7'b1001111;
            4'h2:    g = 7'b0010010;
            4'h3:    g = 7'b0000110;
            4'h4:    g = 7'b1001100;
            4'h5:    g = 7'b0100100;
            4'h6:    g = 7'b0100000;
            4'h7:    g = 7'b0001111;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0000100;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b1100000;
            4'hC:    g = 7'b0110001;
            4'hD:    g = 7'b1000010;
            4'hE:    g = 7'b0110000;
            default: g = 7'b0111000;
        endcase
        if (code > 4'd9 && HEX_MODE == 0) g = 7'b1111111;
        return g;
    endfunction

    // NOTE: every variable gets a default first so no latch is inferred.
    always_comb begin
        logic zero_run;
        glyph    = '1;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (snap_digits[i] == 4'h0);
            if (snap_blank[i])
                glyph[i] = 8'hFF;
            else if (snap_lzs && i != 0 && zero_run)
                glyph[i] = {7'b1111111, ~snap_dp[i]};
            else
                glyph[i] = {decode(snap_digits[i]), ~snap_dp[i]};
        end
    end

    always_comb begin
        en_next  = '1;
        seg_next = 8'hFF;
        if (!in_blank) begin
            for (int i = 0; i < NUM_DIGITS; i++)
                en_next[i] = (idx != IDX_W'(i));
            seg_next = glyph[idx];
        end
    end

    // NOTE: clocked state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt        <= '0;
            idx         <= '0;
            // NOTE: snapshot regs are reset too (blank all 1s) so the first frame is dark.
            snap_digits <= '0;
            snap_dp     <= '0;
            snap_blank  <= '1;
            snap_lzs    <= 1'b0;
            seg_q       <= 8'hFF;
            en_q        <= '1;
            tick_q      <= 1'b0;
        end else begin
            pcnt <= slot_end ? '0 : pcnt + 1'b1;
            if (slot_end)
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            if (frame_end) begin
                snap_digits <= bus.digits_in;
                snap_dp     <= bus.dp_in;
                snap_blank  <= bus.blank_in;
                snap_lzs    <= bus.lzs_en;
            end
            tick_q <= frame_end;
            en_q   <= en_next;
            seg_q  <= seg_next;
        end
    end

    assign bus.segment    = seg_q;
    assign bus.enable     = en_q;
    assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench: two scanners (HEX_MODE 0 and 1) share stimulus; a
// scoreboard holds per-slot expectations, a negedge monitor compares them.
module tb_seg7_scan_ctrl;
    localparam int N   = 4;
    localparam int DIV = 8;
    localparam int BLK = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    seg7_scan_ctrl_if #(.NUM_DIGITS(N)) if0 ();
    seg7_scan_ctrl_if #(.NUM_DIGITS(N)) if1 ();

    seg7_scan_ctrl #(.NUM_DIGITS(N), .DIV(DIV), .BLANK_CYCLES(BLK), .HEX_MODE(0))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    seg7_scan_ctrl #(.NUM_DIGITS(N), .DIV(DIV), .BLANK_CYCLES(BLK), .HEX_MODE(1))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    typedef struct {
        logic [15:0]     digits;
        logic [3:0]      dp;
        logic [3:0]      blank;
        logic            lzs;
        logic [3:0][7:0] seg_h0;
        logic [3:0][7:0] seg_h1;
    } vec_t;

    typedef struct {
        logic [3:0] en;
        logic [7:0] s0;
        logic [7:0] s1;
    } exp_t;

    vec_t vecs [11];
    exp_t sb [$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        if0.digits_in = v.digits; if1.digits_in = v.digits;
        if0.dp_in     = v.dp;     if1.dp_in     = v.dp;
        if0.blank_in  = v.blank;  if1.blank_in  = v.blank;
        if0.lzs_en    = v.lzs;    if1.lzs_en    = v.lzs;
    endtask

    task automatic push_frame(input vec_t v);
        exp_t e;
        for (int i = 0; i < N; i++) begin
            e.en = ~(4'b0001 << i);
            e.s0 = v.seg_h0[i];
            e.s1 = v.seg_h1[i];
            sb.push_back(e);
        end
    endtask

    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!if0.frame_tick && n < 100);
        if (!if0.frame_tick) begin
            total++;
            bad++;
            $display("FAIL tick_timeout: got no frame_tick expected one within 100 cycles");
        end
    endtask

    // k counts negedges from a frame boundary; state seen at negedge k is slot step k-1.
    task automatic check_scan(input bit dark);
        for (int k = 1; k <= 32; k++) begin
            int s, pc, ix;
            logic [3:0] exp_en;
            @(negedge clk);
            s  = k - 1;
            pc = s % DIV;
            ix = s / DIV;
            exp_en = (pc < BLK) ? 4'hF : ~(4'b0001 << ix);
            check("scan_enable", if0.enable, exp_en);
            check("scan_tick", if0.frame_tick, (k == 32));
            if (dark) begin
                check("dark_seg0", if0.segment, 8'hFF);
                check("dark_seg1", if1.segment, 8'hFF);
            end
        end
    endtask

    exp_t       cur;
    bit         cur_v   = 1'b0;
    logic [3:0] prev_en = 4'hF;

    always @(negedge clk) begin
        if (if0.enable == 4'hF) begin
            check("gap_seg0", if0.segment, 8'hFF);
            check("gap_seg1", if1.segment, 8'hFF);
        end else begin
            if (prev_en == 4'hF) begin
                if (sb.size() > 0) begin
                    cur   = sb.pop_front();
                    cur_v = 1'b1;
                end else begin
                    cur_v = 1'b0;
                end
            end
            if (cur_v) begin
                check("slot_en0", if0.enable, cur.en);
                check("slot_en1", if1.enable, cur.en);
                check("slot_seg_hex0", if0.segment, cur.s0);
                check("slot_seg_hex1", if1.segment, cur.s1);
            end
        end
        prev_en = if0.enable;
    end

    initial begin
        vec_t v_one, v_two, v_main;
        //             digits    dp     blank  lzs   hex0 d3..d0                   hex1 d3..d0
        vecs[0]  = '{16'h4321, 4'h0, 4'h0, 1'b0, {8'h99,8'h0D,8'h25,8'h9F}, {8'h99,8'h0D,8'h25,8'h9F}};
        vecs[1]  = '{16'h0050, 4'h0, 4'h0, 1'b1, {8'hFF,8'hFF,8'h49,8'h03}, {8'hFF,8'hFF,8'h49,8'h03}};
        vecs[2]  = '{16'h0000, 4'h0, 4'h0, 1'b1, {8'hFF,8'hFF,8'hFF,8'h03}, {8'hFF,8'hFF,8'hFF,8'h03}};
        vecs[3]  = '{16'h0000, 4'h8, 4'h0, 1'b1, {8'hFE,8'hFF,8'hFF,8'h03}, {8'hFE,8'hFF,8'hFF,8'h03}};
        vecs[4]  = '{16'h000A, 4'h0, 4'h0, 1'b0, {8'h03,8'h03,8'h03,8'hFF}, {8'h03,8'h03,8'h03,8'h11}};
        vecs[5]  = '{16'h000F, 4'h0, 4'h0, 1'b0, {8'h03,8'h03,8'h03,8'hFF}, {8'h03,8'h03,8'h03,8'h71}};
        vecs[6]  = '{16'h0030, 4'h2, 4'h0, 1'b0, {8'h03,8'h03,8'h0C,8'h03}, {8'h03,8'h03,8'h0C,8'h03}};
        vecs[7]  = '{16'h0030, 4'h2, 4'h2, 1'b0, {8'h03,8'h03,8'hFF,8'h03}, {8'h03,8'h03,8'hFF,8'h03}};
        vecs[8]  = '{16'hBCDE, 4'h5, 4'h0, 1'b1, {8'hFF,8'hFE,8'hFF,8'hFE}, {8'hC1,8'h62,8'h85,8'h60}};
        vecs[9]  = '{16'h9876, 4'h0, 4'h4, 1'b1, {8'h09,8'hFF,8'h1F,8'h41}, {8'h09,8'hFF,8'h1F,8'h41}};
        vecs[10] = '{16'h0102, 4'h0, 4'h0, 1'b1, {8'hFF,8'h9F,8'h03,8'h25}, {8'hFF,8'h9F,8'h03,8'h25}};
        v_one  = '{16'h1111, 4'h0, 4'h0, 1'b0, {4{8'h9F}}, {4{8'h9F}}};
        v_two  = '{16'h2222, 4'h0, 4'h0, 1'b0, {4{8'h25}}, {4{8'h25}}};
        v_main = vecs[0];

        drive(vecs[0]);
        #1 rst_n = 1'b0;
        #2;
        check("rst_enable", if0.enable, 4'hF);
        check("rst_seg0", if0.segment, 8'hFF);
        check("rst_seg1", if1.segment, 8'hFF);
        check("rst_tick", if0.frame_tick, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Inputs for the next vector are driven while the current one is on display.
        for (int v = 0; v < 11; v++) begin
            drive(vecs[v]);
            wait_tick();
            push_frame(vecs[v]);
        end

        // Snapshot: a change during slot 2 must not reach the frame on display.
        drive(v_one);
        wait_tick();
        push_frame(v_one);
        repeat (20) @(negedge clk);
        drive(v_two);
        wait_tick();
        push_frame(v_two);
        drive(v_main);
        check_scan(1'b0);
        push_frame(v_main);

        // Reset in the middle of slot 3.
        repeat (28) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_enable0", if0.enable, 4'hF);
        check("midrst_enable1", if1.enable, 4'hF);
        check("midrst_seg0", if0.segment, 8'hFF);
        check("midrst_seg1", if1.segment, 8'hFF);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_scan(1'b1);
        push_frame(v_main);
        wait_tick();
        check("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
